// File: rtl/cic_comb_if.sv
// Sample bus for the CIC comb chain: decimated input stream, combed output stream
// and the frame-sync error flag.
interface cic_comb_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 2
);
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             in_valid;
  logic             in_sof;
  logic [WIDTH-1:0] in_data;
  logic             clr_err;
  logic             out_valid;
  logic [CW-1:0]    out_chan;
  logic [WIDTH-1:0] out_data;
  logic             sync_err;

  modport master (
    output in_valid, in_sof, in_data, clr_err,
    input  out_valid, out_chan, out_data, sync_err
  );

  modport slave (
    input  in_valid, in_sof, in_data, clr_err,
    output out_valid, out_chan, out_data, sync_err
  );
endinterface

// File: rtl/cic_comb_chain.sv
// Time-multiplexed multi-stage CIC comb section: y[n] = x[n] - x[n-M] per stage,
// with independent per-channel history and modulo 2^WIDTH arithmetic.
module cic_comb_chain #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STAGES     = 4,
  parameter int unsigned DIFF_DELAY = 1,
  parameter int unsigned CHANNELS   = 2
) (
  input logic       clk,
  input logic       rst,
  cic_comb_if.slave bus
);

  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

  typedef logic [WIDTH-1:0] word_t;

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] chan;
    word_t         data;
  } slot_t;

  // slot 0 is the tagged input sample, slot s+1 is the output of comb stage s
  slot_t         slot_q [STAGES+1];
  slot_t         slot_d [STAGES+1];
  word_t         hist_q [STAGES][CHANNELS][DIFF_DELAY];
  word_t         hist_d [STAGES][CHANNELS][DIFF_DELAY];
  logic [CW-1:0] chan_cnt_q, chan_cnt_d;
  logic [CW-1:0] in_tag_c;
  logic          sync_err_q, sync_err_d;

  always_comb begin
    slot_d     = slot_q;
    hist_d     = hist_q;
    chan_cnt_d = chan_cnt_q;
    sync_err_d = sync_err_q;
    in_tag_c   = bus.in_sof ? '0 : chan_cnt_q;

    slot_d[0].valid = bus.in_valid;
    if (bus.in_valid) begin
      slot_d[0].chan = in_tag_c;
      slot_d[0].data = bus.in_data;
      chan_cnt_d     = (in_tag_c == LAST_CHAN) ? '0 : CW'(in_tag_c + CW'(1));
    end

    // a misaligned frame start overrides a concurrent clear
    if (bus.clr_err) sync_err_d = 1'b0;
    if (bus.in_valid && bus.in_sof && (chan_cnt_q != '0)) sync_err_d = 1'b1;

    for (int s = 0; s < STAGES; s++) begin
      slot_d[s+1].valid = slot_q[s].valid;
      if (slot_q[s].valid) begin
        slot_d[s+1].chan = slot_q[s].chan;
        for (int c = 0; c < CHANNELS; c++) begin
          if (slot_q[s].chan == CW'(c)) begin
            slot_d[s+1].data = slot_q[s].data - hist_q[s][c][DIFF_DELAY-1];
            for (int m = DIFF_DELAY - 1; m > 0; m--) begin
              hist_d[s][c][m] = hist_q[s][c][m-1];
            end
            hist_d[s][c][0] = slot_q[s].data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= STAGES; s++) begin
        slot_q[s] <= '0;
      end
      for (int s = 0; s < STAGES; s++) begin
        for (int c = 0; c < CHANNELS; c++) begin
          for (int m = 0; m < DIFF_DELAY; m++) begin
            hist_q[s][c][m] <= '0;
          end
        end
      end
      chan_cnt_q <= '0;
      sync_err_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      hist_q     <= hist_d;
      chan_cnt_q <= chan_cnt_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.out_valid = slot_q[STAGES].valid;
  assign bus.out_chan  = slot_q[STAGES].chan;
  assign bus.out_data  = slot_q[STAGES].data;
  assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_cic_comb_chain.sv
// Directed bench for cic_comb_chain across four parameter sets sharing clk/rst.
module tb_cic_comb_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cic_comb_if #(.WIDTH(32), .CHANNELS(1)) a_if ();
  cic_comb_if #(.WIDTH(32), .CHANNELS(1)) b_if ();
  cic_comb_if #(.WIDTH(8),  .CHANNELS(1)) c_if ();
  cic_comb_if #(.WIDTH(32), .CHANNELS(2)) d_if ();

  cic_comb_chain #(.WIDTH(32), .STAGES(4), .DIFF_DELAY(1), .CHANNELS(1))
    u_a (.clk(clk), .rst(rst), .bus(a_if));
  cic_comb_chain #(.WIDTH(32), .STAGES(1), .DIFF_DELAY(1), .CHANNELS(1))
    u_b (.clk(clk), .rst(rst), .bus(b_if));
  cic_comb_chain #(.WIDTH(8), .STAGES(1), .DIFF_DELAY(1), .CHANNELS(1))
    u_c (.clk(clk), .rst(rst), .bus(c_if));
  cic_comb_chain #(.WIDTH(32), .STAGES(1), .DIFF_DELAY(2), .CHANNELS(2))
    u_d (.clk(clk), .rst(rst), .bus(d_if));

  logic [31:0] a_exp [6] = '{32'd1, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] b_in  [3] = '{32'd5, 32'd5, 32'd5};
  logic [31:0] b_exp [3] = '{32'd5, 32'd0, 32'd0};
  logic [7:0]  c_in  [4] = '{8'h7F, 8'h80, 8'h00, 8'hFF};
  logic [7:0]  c_exp [4] = '{8'h7F, 8'h01, 8'h80, 8'hFF};
  logic [31:0] d_in  [8] = '{32'd10, 32'd0, 32'd10, 32'd1, 32'd10, 32'd2, 32'd10, 32'd3};
  logic [31:0] d_exp [8] = '{32'd10, 32'd0, 32'd10, 32'd1, 32'd0, 32'd2, 32'd0, 32'd2};

  int sent, idx, first_in, first_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.in_valid = 1'b0; a_if.in_sof = 1'b0; a_if.in_data = '0; a_if.clr_err = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_sof = 1'b0; b_if.in_data = '0; b_if.clr_err = 1'b0;
    c_if.in_valid = 1'b0; c_if.in_sof = 1'b0; c_if.in_data = '0; c_if.clr_err = 1'b0;
    d_if.in_valid = 1'b0; d_if.in_sof = 1'b0; d_if.in_data = '0; d_if.clr_err = 1'b0;

    // reset held with samples presented
    a_if.in_valid = 1'b1; a_if.in_data = 32'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out_valid", 64'(a_if.out_valid), 64'd0);
      chk("rst_out_data", 64'(a_if.out_data), 64'd0);
      chk("rst_sync_err", 64'(a_if.sync_err), 64'd0);
    end
    rst = 1'b0; a_if.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_discard", 64'(a_if.out_valid), 64'd0);
    end

    // unit step through 4 stages, without and with gaps
    for (int g = 0; g < 2; g++) begin
      rst = 1'b1; tick(); rst = 1'b0;
      sent = 0; idx = 0; first_in = -1; first_out = -1;
      for (int cyc = 0; cyc < 40; cyc++) begin
        if (sent < 6 && (g == 0 || cyc >= 20 || $urandom_range(0, 2) != 0)) begin
          a_if.in_valid = 1'b1; a_if.in_data = 32'd1;
          if (first_in < 0) first_in = cyc;
          sent++;
        end else begin
          a_if.in_valid = 1'b0;
        end
        tick();
        if (a_if.out_valid) begin
          if (first_out < 0) first_out = cyc;
          if (idx < 6) chk("a_step_data", 64'(a_if.out_data), 64'(a_exp[idx]));
          idx++;
        end
      end
      a_if.in_valid = 1'b0;
      chk("a_step_count", 64'(idx), 64'd6);
      chk("a_latency", 64'(first_out - first_in), 64'd4);
    end

    // reset mid-flight drops the in-flight sample
    a_if.in_valid = 1'b1; a_if.in_data = 32'd9; tick();
    a_if.in_valid = 1'b0; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_out", 64'(a_if.out_valid), 64'd0);
    end

    // single stage, constant input
    idx = 0; first_in = -1; first_out = -1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc < 3) begin
        b_if.in_valid = 1'b1; b_if.in_data = b_in[cyc];
        if (first_in < 0) first_in = cyc;
      end else begin
        b_if.in_valid = 1'b0;
      end
      tick();
      if (b_if.out_valid) begin
        if (first_out < 0) first_out = cyc;
        if (idx < 3) chk("b_data", 64'(b_if.out_data), 64'(b_exp[idx]));
        idx++;
      end
    end
    chk("b_count", 64'(idx), 64'd3);
    chk("b_latency", 64'(first_out - first_in), 64'd1);

    // 8-bit wrap-around
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc < 4) begin
        c_if.in_valid = 1'b1; c_if.in_data = c_in[cyc];
      end else begin
        c_if.in_valid = 1'b0;
      end
      tick();
      if (c_if.out_valid) begin
        if (idx < 4) chk("c_wrap_data", 64'(c_if.out_data), 64'(c_exp[idx]));
        idx++;
      end
    end
    chk("c_count", 64'(idx), 64'd4);
    chk("c_hold_valid", 64'(c_if.out_valid), 64'd0);
    chk("c_hold_data", 64'(c_if.out_data), 64'hFF);

    // two interleaved channels, M=2, one bubble mid-stream
    idx = 0; sent = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (sent < 8 && cyc != 3) begin
        d_if.in_valid = 1'b1; d_if.in_data = d_in[sent];
        d_if.in_sof = (sent % 2 == 0);
        sent++;
      end else begin
        d_if.in_valid = 1'b0; d_if.in_sof = 1'b0;
      end
      tick();
      if (d_if.out_valid) begin
        if (idx < 8) begin
          chk("d_data", 64'(d_if.out_data), 64'(d_exp[idx]));
          chk("d_chan", 64'(d_if.out_chan), 64'(idx % 2));
        end
        idx++;
      end
    end
    d_if.in_valid = 1'b0; d_if.in_sof = 1'b0;
    chk("d_count", 64'(idx), 64'd8);
    chk("d_no_err", 64'(d_if.sync_err), 64'd0);

    // frame misalignment: sof on second sample of a frame
    d_if.in_valid = 1'b1; d_if.in_sof = 1'b1; d_if.in_data = 32'd100; tick();
    chk("sof_aligned", 64'(d_if.sync_err), 64'd0);
    d_if.in_data = 32'd200; tick();
    d_if.in_valid = 1'b0; d_if.in_sof = 1'b0;
    chk("sof_err_set", 64'(d_if.sync_err), 64'd1);
    chk("sof_prev_data", 64'(d_if.out_data), 64'd90);
    tick();
    chk("resync_valid", 64'(d_if.out_valid), 64'd1);
    chk("resync_chan", 64'(d_if.out_chan), 64'd0);
    chk("resync_data", 64'(d_if.out_data), 64'd190);
    chk("err_sticky", 64'(d_if.sync_err), 64'd1);
    d_if.clr_err = 1'b1; tick(); d_if.clr_err = 1'b0;
    chk("err_cleared", 64'(d_if.sync_err), 64'd0);

    // set and clear together: set wins
    d_if.in_valid = 1'b1; d_if.in_sof = 1'b1; d_if.in_data = 32'd5; d_if.clr_err = 1'b1;
    tick();
    d_if.in_valid = 1'b0; d_if.in_sof = 1'b0;
    chk("set_beats_clr", 64'(d_if.sync_err), 64'd1);
    tick(); d_if.clr_err = 1'b0;
    chk("clr_again", 64'(d_if.sync_err), 64'd0);

    // sof without valid leaves the channel counter alone
    d_if.in_sof = 1'b1; tick(); d_if.in_sof = 1'b0;
    d_if.in_valid = 1'b1; d_if.in_data = 32'd6; tick(); d_if.in_valid = 1'b0;
    chk("lone_sof_no_err", 64'(d_if.sync_err), 64'd0);
    tick();
    chk("lone_sof_valid", 64'(d_if.out_valid), 64'd1);
    chk("lone_sof_chan", 64'(d_if.out_chan), 64'd1);
    chk("lone_sof_data", 64'(d_if.out_data), 64'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cic_comb_chain.md
Name: cic_comb_chain

Overview:
- Multi-stage, multi-channel, time-multiplexed comb section for CIC decimators.
- Sits after the integrator section and rate-change strobe; consumes decimated samples and feeds the output gain/truncation stage.
- Generalises the single-stage comb with STAGES cascaded combs, differential delay DIFF_DELAY and CHANNELS interleaved streams sharing one datapath.
- Sign convention: each stage computes y[n] = x[n] - x[n-M], M = DIFF_DELAY.

Parameters:
- WIDTH, 32: data width; all arithmetic is modulo 2^WIDTH.
- STAGES, 4: number of cascaded comb stages (1..8).
- DIFF_DELAY, 1: differential delay M per stage (1 or 2).
- CHANNELS, 2: number of interleaved channels (1..16); CW = max(1, clog2(CHANNELS)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input sample strobe; at most one sample per cycle, arbitrary gaps allowed.
- in_sof  in  1  frame start; qualified by in_valid, marks the channel-0 sample.
- in_data  in  WIDTH  input sample (two's complement).
- out_valid  out  1  output sample strobe.
- out_chan  out  CW  channel index of out_data.
- out_data  out  WIDTH  comb chain output.
- sync_err  out  1  sticky error flag: frame misalignment detected.
- clr_err  in  1  clears sync_err.

Behaviour:
- Reset, clk/rst as decided: synchronous, active-high rst on clk.
  - Clears all history words, stage registers, valid/channel pipeline and channel counter to 0.
  - out_valid=0, out_chan=0, out_data=0, sync_err=0.
  - rst has priority over every other input.
  - Reset mid-operation discards all in-flight samples; no out_valid is produced for them.
- Channel tracking:
  - An internal counter chan_cnt tags each accepted sample (in_valid=1), then advances. It wraps CHANNELS-1 -> 0.
  - If in_valid & in_sof, the sample is tagged channel 0 and chan_cnt becomes 1 (0 when CHANNELS=1).
  - If in_valid & in_sof while chan_cnt != 0, sync_err is set; the resync still happens.
  - clr_err clears sync_err; a simultaneous set wins over clear.
  - in_sof without in_valid is ignored.
- Pipeline:
  - One register per stage; the valid bit and channel tag travel with the data.
  - Latency: sample accepted at edge k yields out_valid at edge k+STAGES.
  - Throughput: one sample per cycle.
  - Bubbles (in_valid=0) propagate as invalid slots and never modify history.
- Stage s, on a valid slot with channel c:
  - out = d - hist[s][c][M-1]; hist[s][c] shifts in d.
  - Histories are per channel, so interleaving and gaps do not affect per-channel results.
  - Storage: STAGES*CHANNELS*DIFF_DELAY words of WIDTH bits, in registers.
- Arithmetic:
  - Wrap-around subtraction, no saturation, no growth; CIC modular arithmetic relies on this.
  - Output is bit-exact with a per-channel reference model in modulo 2^WIDTH.
- out_data and out_chan hold their value when out_valid=0. They update only on valid slots.

Test Plan:
- Reset: drive rst for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, sync_err=0; no output for samples presented during reset.
- STAGES=1, M=1, CHANNELS=1; inputs 5,5,5 -> out 5,0,0, each one cycle after input.
- Defaults with CHANNELS=1; step of 1 -> out 1,-3,3,-1,0,0 (0xFFFFFFFD for -3), first output 4 cycles after first input. Insert random gaps -> identical sequence.
- WIDTH=8, STAGES=1; inputs 0x7F,0x80 -> second output 0x01. Inputs 0x00,0xFF -> 0xFF. No saturation.
- CHANNELS=2, STAGES=1, M=2; ch0 constant 10, ch1 ramp 0,1,2,3 interleaved with in_sof on ch0 -> ch0 out 10,10,0,0; ch1 out 0,1,2,2; out_chan alternates 0,1.
- Assert in_sof on the 2nd sample of a frame -> sync_err=1 and that sample tagged chan 0. clr_err -> sync_err=0. Simultaneous sof-error and clr_err -> sync_err stays 1.
